// File: rtl/req_arbiter_fsm.sv
// Three-way request arbiter: grant, hold, forced release on timeout, one-cycle turnaround gap.
// Latency: req sampled in IDLE -> registered gnt one clock later; gnt-low gap of 2 cycles between grants.
// Backpressure: owner holds req to keep the grant; non-owners wait (no preemption) until the gap/idle cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   req     request vector, req[0]=a, req[1]=b, req[2]=c
//   gnt     registered one-hot grant, zero when nobody owns the resource
//   gnt_id  index of current owner, 0 when idle
//   busy    high while a grant is active (== |gnt)
//   timeout one-cycle pulse in the gap cycle after a forced release
module req_arbiter_fsm #(
    parameter int RR_MODE  = 0,   // 0: fixed priority req[0] highest, 1: round-robin
    parameter int MAX_HOLD = 8    // max grant length in cycles, 0 disables the timeout
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_cnt_nxt;
    logic [1:0]    owner, owner_nxt;       // survives into GAP, unlike gnt_id
    logic [1:0]    rr_last, rr_last_nxt;
    logic          mask_vld, mask_vld_nxt; // last grant was force-released
    logic [1:0]    mask_idx, mask_idx_nxt;
    logic [2:0]    gnt_nxt;
    logic [1:0]    gnt_id_nxt;
    logic          busy_nxt, timeout_nxt;
    logic [2:0]    cand;
    logic [1:0]    win;

    // Candidates loop from lowest to highest priority so the last hit wins.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] p;
        p = 2'd0;
        if (RR_MODE == 0) begin
            for (int j = 2; j >= 0; j--)
                if (r[j]) p = 2'(j);
        end else begin
            for (int i = 3; i >= 1; i--) begin
                int j;
                j = (int'(last) + i) % 3;
                if (r[j]) p = 2'(j);
            end
        end
        return p;
    endfunction

    // The timed-out requester sits out one arbitration, but only if someone else is waiting.
    always_comb begin
        cand = req;
        if (mask_vld && ((req & ~(3'b001 << mask_idx)) != 3'b000))
            cand = req & ~(3'b001 << mask_idx);
        win = pick(cand, rr_last);
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        owner_nxt    = owner;
        rr_last_nxt  = rr_last;
        mask_vld_nxt = mask_vld;
        mask_idx_nxt = mask_idx;
        gnt_nxt      = gnt;
        gnt_id_nxt   = gnt_id;
        busy_nxt     = busy;
        timeout_nxt  = 1'b0;

        case (state)
            IDLE: begin
                gnt_nxt    = 3'b000;
                gnt_id_nxt = 2'd0;
                busy_nxt   = 1'b0;
                if (req != 3'b000) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = 3'b001 << win;
                    gnt_id_nxt   = win;
                    owner_nxt    = win;
                    busy_nxt     = 1'b1;
                    hold_cnt_nxt = '0;
                    mask_vld_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (hold_cnt != '1)
                    hold_cnt_nxt = hold_cnt + 1'b1;
                // A release on the timeout cycle is a normal release: checked first.
                if (!req[owner]) begin
                    state_nxt    = GAP;
                    gnt_nxt      = 3'b000;
                    gnt_id_nxt   = 2'd0;
                    busy_nxt     = 1'b0;
                    mask_vld_nxt = 1'b0;
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                    state_nxt    = GAP;
                    gnt_nxt      = 3'b000;
                    gnt_id_nxt   = 2'd0;
                    busy_nxt     = 1'b0;
                    timeout_nxt  = 1'b1;
                    mask_vld_nxt = 1'b1;
                    mask_idx_nxt = owner;
                end
            end
            GAP: begin
                rr_last_nxt = owner;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                gnt_nxt    = 3'b000;
                gnt_id_nxt = 2'd0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            owner    <= 2'd0;
            rr_last  <= 2'd2;
            mask_vld <= 1'b0;
            mask_idx <= 2'd0;
            gnt      <= 3'b000;
            gnt_id   <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            owner    <= owner_nxt;
            rr_last  <= rr_last_nxt;
            mask_vld <= mask_vld_nxt;
            mask_idx <= mask_idx_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_req_arbiter_fsm.sv
// Bench for req_arbiter_fsm: two instances (fixed-priority with MAX_HOLD=4, round-robin without timeout).
// Stimulus pushes expected grant records; a negedge monitor closes each grant and compares.
// All waits are fixed cycle counts, so the run always terminates.
module tb_req_arbiter_fsm;

    typedef struct {
        logic [2:0] g;
        logic [1:0] id;
        int         len;
        logic       to;
        int         gap;   // -1 = not checked
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [2:0] req_a, req_b, gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       busy_a, busy_b, to_a, to_b;

    int n_chk  = 0;
    int n_fail = 0;

    ev_t        exp_a[$];
    ev_t        exp_b[$];
    bit         active[2]  = '{1'b0, 1'b0};
    int         cur_len[2] = '{0, 0};
    int         low_len[2] = '{-1, -1};
    int         gap_st[2]  = '{-1, -1};
    logic [2:0] cur_g[2];
    logic [1:0] cur_i[2];

    req_arbiter_fsm #(.RR_MODE(0), .MAX_HOLD(4)) u_a (
        .clk(clk), .rst(rst_a), .req(req_a), .gnt(gnt_a),
        .gnt_id(id_a), .busy(busy_a), .timeout(to_a)
    );

    req_arbiter_fsm #(.RR_MODE(1), .MAX_HOLD(0)) u_b (
        .clk(clk), .rst(rst_b), .req(req_b), .gnt(gnt_b),
        .gnt_id(id_b), .busy(busy_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input int d, input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0d, expected %0d (t=%0t)", d, nm, act, expv, $time);
        end
    endtask

    task automatic push(input int d, input logic [2:0] g, input logic [1:0] id,
                        input int len, input logic to, input int gap);
        ev_t e;
        e.g = g; e.id = id; e.len = len; e.to = to; e.gap = gap;
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    task automatic mon(input int d, input logic r, input logic [2:0] g,
                       input logic [1:0] id, input logic b, input logic t);
        ev_t e;
        int  exp_id;
        if (r) begin
            active[d]  = 1'b0;
            low_len[d] = -1;
            return;
        end
        exp_id = g[2] ? 2 : (g[1] ? 1 : 0);
        chk(d, "onehot0", int'($countones(g) <= 1), 1);
        chk(d, "busy_eq_or_gnt", b, |g);
        chk(d, "gnt_id", id, exp_id);
        if (g != 3'b000) begin
            chk(d, "timeout_while_gnt", t, 0);
            if (!active[d]) begin
                active[d]  = 1'b1;
                cur_g[d]   = g;
                cur_i[d]   = id;
                cur_len[d] = 1;
                gap_st[d]  = low_len[d];
            end else begin
                chk(d, "gnt_stable", g, cur_g[d]);
                cur_len[d]++;
            end
        end else if (active[d]) begin
            active[d]  = 1'b0;
            low_len[d] = 1;
            if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
                chk(d, "unexpected_grant", int'(cur_g[d]), 0);
            end else begin
                e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
                chk(d, "grant_gnt", cur_g[d], e.g);
                chk(d, "grant_id", cur_i[d], e.id);
                chk(d, "grant_len", cur_len[d], e.len);
                chk(d, "grant_timeout", t, e.to);
                if (e.gap >= 0)
                    chk(d, "gap_len", gap_st[d], e.gap);
            end
        end else begin
            chk(d, "timeout_idle", t, 0);
            if (low_len[d] >= 0) low_len[d]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst_a, gnt_a, id_a, busy_a, to_a);
        mon(1, rst_b, gnt_b, id_b, busy_b, to_b);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [2:0] rr_own[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] rr_id[4]  = '{2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = 3'b111; req_b = 3'b111;

        // Reset holds everything low even with all requests asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(0, "rst_gnt", gnt_a, 0);  chk(0, "rst_busy", busy_a, 0);  chk(0, "rst_to", to_a, 0);
            chk(1, "rst_gnt", gnt_b, 0);  chk(1, "rst_busy", busy_b, 0);  chk(1, "rst_to", to_b, 0);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        req_a = 3'b000; req_b = 3'b000;
        cyc(3);

        // Fixed priority: 110 -> b first, then c after a 2-cycle gap.
        push(0, 3'b010, 2'd1, 2, 1'b0, -1);
        push(0, 3'b100, 2'd2, 1, 1'b0, 2);
        req_a = 3'b110; cyc(2);
        req_a = 3'b100; cyc(3);
        req_a = 3'b000; cyc(3);

        // Timeout with a single requester: 4 cycles, pulse, regrant to the same one.
        push(0, 3'b001, 2'd0, 4, 1'b1, -1);
        push(0, 3'b001, 2'd0, 2, 1'b0, 2);
        req_a = 3'b001; cyc(8);
        req_a = 3'b000; cyc(3);

        // Timeout mask: a times out -> b, b times out -> a.
        push(0, 3'b001, 2'd0, 4, 1'b1, -1);
        push(0, 3'b010, 2'd1, 4, 1'b1, 2);
        push(0, 3'b001, 2'd0, 2, 1'b0, 2);
        req_a = 3'b011; cyc(14);
        req_a = 3'b000; cyc(3);

        // Release on the timeout cycle is a normal release: no pulse, no mask, a wins again.
        push(0, 3'b001, 2'd0, 4, 1'b0, -1);
        push(0, 3'b001, 2'd0, 2, 1'b0, 2);
        req_a = 3'b011; cyc(4);
        req_a = 3'b010; cyc(1);
        req_a = 3'b011; cyc(3);
        req_a = 3'b000; cyc(3);

        // Async reset mid-grant, then arbitration restarts from IDLE.
        push(0, 3'b100, 2'd2, 1, 1'b0, -1);
        req_a = 3'b010; cyc(2);
        chk(0, "pre_rst_gnt", gnt_a, 3'b010);
        #2 rst_a = 1'b1;
        #1;
        chk(0, "async_rst_gnt", gnt_a, 0);
        chk(0, "async_rst_busy", busy_a, 0);
        chk(0, "async_rst_id", id_a, 0);
        chk(0, "async_rst_to", to_a, 0);
        @(negedge clk);
        #2 rst_a = 1'b0;
        req_a = 3'b100;
        @(negedge clk);
        req_a = 3'b000; cyc(3);

        // Round-robin with all requesting; each owner releases after 2 cycles.
        for (int k = 0; k < 4; k++)
            push(1, rr_own[k], rr_id[k], 2, 1'b0, (k == 0) ? -1 : 2);
        req_b = 3'b111; cyc(2);
        for (int k = 0; k < 4; k++) begin
            req_b = 3'b111 & ~rr_own[k]; cyc(1);
            req_b = (k == 3) ? 3'b000 : 3'b111; cyc(3);
        end

        // No timeout when MAX_HOLD=0: a long hold ends only on release.
        push(1, 3'b100, 2'd2, 12, 1'b0, -1);
        req_b = 3'b100; cyc(12);
        req_b = 3'b000; cyc(3);

        chk(0, "exp_left", exp_a.size(), 0);
        chk(1, "exp_left", exp_b.size(), 0);
        chk(0, "open_grant", int'(active[0]), 0);
        chk(1, "open_grant", int'(active[1]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
